pwl_clk_quantizer: RTL and testbench



---
 rtl/pwl_quant_pkg.sv | 53 +++++
 rtl/pwl_clk_quantizer_sampler.sv | 42 ++++
 rtl/pwl_clk_quantizer.sv | 105 ++++++++++
 tb/tb_pwl_clk_quantizer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pwl_quant_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the clocked PWL quantizer: code struct, accumulator sizing,
// PWL evaluation and saturating round-half-away-from-zero quantization.
package pwl_quant_pkg;

    localparam int unsigned CODE_W_MAX  = 16;
    // Simulation time unit of the rtl files, used to turn $realtime into seconds.
    localparam real         TIME_UNIT_S = 1.0e-9;

    typedef struct packed {
        logic                         sat;
        logic signed [CODE_W_MAX-1:0] code;
    } code_t;

    function automatic int unsigned acc_w(input int unsigned nbit, input int unsigned dec);
        return nbit + $clog2(dec);
    endfunction

    function automatic real pwl_value(input real a, input real b, input real t0, input real t);
        return a + b * (t - t0);
    endfunction

    function automatic code_t quantize_sat(input real v, input real lsb, input int unsigned nbit);
        code_t res;
        int    max_c;
        int    min_c;
        real   x;
        real   xr;
        max_c   = (1 << (nbit - 1)) - 1;
        min_c   = -(1 << (nbit - 1));
        x       = v / lsb;
        // Truncating x +/- 0.5 toward zero gives round-half-away-from-zero.
        xr      = (x >= 0.0) ? x + 0.5 : x - 0.5;
        res.sat = 1'b0;
        if (xr >= real'(max_c) + 1.0) begin
            res.code = CODE_W_MAX'(max_c);
            res.sat  = 1'b1;
        end else if (xr <= real'(min_c) - 1.0) begin
            res.code = CODE_W_MAX'(min_c);
            res.sat  = 1'b1;
        end else begin
            res.code = CODE_W_MAX'($rtoi(xr));
        end
        return res;
    endfunction

    function automatic code_t sample_pwl(input real a, input real b, input real t0,
                                         input real t, input real vofs, input real lsb,
                                         input int unsigned nbit);
        return quantize_sat(pwl_value(a, b, t0, t) - vofs, lsb, nbit);
    endfunction

endpackage

// File: rtl/pwl_clk_quantizer_sampler.sv
`timescale 1ns/1ps
// pwl_sampler: evaluates the PWL input at each enabled rising edge and registers the
// saturated instantaneous code together with its clamp flag.
module pwl_sampler
    import pwl_quant_pkg::*;
#(
    parameter int unsigned NBIT = 8,
    parameter real         LSB  = 0.01,
    parameter real         VOFS = 0.0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  real                    i_in_a,
    input  real                    i_in_b,
    input  real                    i_in_t0,
    output logic signed [NBIT-1:0] o_sample,
    output logic                   o_sat
);

    logic signed [NBIT-1:0] r_sample;
    logic                   r_sat;

    function automatic logic [NBIT:0] edge_code();
        code_t c;
        c = sample_pwl(i_in_a, i_in_b, i_in_t0, $realtime * TIME_UNIT_S, VOFS, LSB, NBIT);
        return {c.sat, NBIT'(c.code)};
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample <= '0;
            r_sat    <= 1'b0;
        end else if (i_en) begin
            {r_sat, r_sample} <= edge_code();
        end
    end

    assign o_sample = r_sample;
    assign o_sat    = r_sat;

endmodule

// File: rtl/pwl_clk_quantizer.sv
`timescale 1ns/1ps
// Clocked PWL quantizer: samples the PWL input, block-averages DEC codes and hands the
// averages out through a valid/ready register with a sticky overflow flag.
module pwl_clk_quantizer
    import pwl_quant_pkg::*;
#(
    parameter int unsigned NBIT = 8,
    parameter int unsigned DEC  = 4,
    parameter real         LSB  = 0.01,
    parameter real         VOFS = 0.0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  real                    i_in_a,
    input  real                    i_in_b,
    input  real                    i_in_t0,
    output logic signed [NBIT-1:0] o_sample,
    output logic                   o_sat,
    output logic signed [NBIT-1:0] o_dout,
    output logic                   o_dout_valid,
    input  logic                   i_dout_ready,
    output logic                   o_ovf
);

    localparam int unsigned SHIFT = $clog2(DEC);
    localparam int unsigned ACC_W = acc_w(NBIT, DEC);
    localparam int unsigned CNT_W = (SHIFT > 0) ? SHIFT : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC - 1);

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [NBIT-1:0]  r_dout;
    logic                    r_dout_valid;
    logic                    r_ovf;

    logic w_last;
    logic w_done;
    logic w_accept;

    pwl_sampler #(
        .NBIT (NBIT),
        .LSB  (LSB),
        .VOFS (VOFS)
    ) u_sampler (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_in_a   (i_in_a),
        .i_in_b   (i_in_b),
        .i_in_t0  (i_in_t0),
        .o_sample (o_sample),
        .o_sat    (o_sat)
    );

    // Same-edge code for the accumulator, so a completion lands on the DEC-th enabled edge
    // rather than one edge after the sampler's register.
    function automatic logic signed [ACC_W-1:0] sum_now();
        code_t                  c;
        logic signed [NBIT-1:0] q;
        c = sample_pwl(i_in_a, i_in_b, i_in_t0, $realtime * TIME_UNIT_S, VOFS, LSB, NBIT);
        q = NBIT'(c.code);
        return r_acc + ACC_W'(q);
    endfunction

    always_comb begin
        w_last   = (r_cnt == CNT_LAST);
        w_done   = i_en & w_last;
        w_accept = r_dout_valid & i_dout_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            if (i_en) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= sum_now();
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            // A completion may replace a result being accepted on the same edge.
            if (w_done && (!r_dout_valid || w_accept)) begin
                r_dout       <= NBIT'(sum_now() >>> SHIFT);
                r_dout_valid <= 1'b1;
            end else if (w_done) begin
                r_ovf <= 1'b1;
            end else if (w_accept) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_pwl_clk_quantizer.sv
`timescale 1ns/1ps
// Directed bench for pwl_clk_quantizer (NBIT=8, DEC=4, LSB=0.01, VOFS=0, 10 ns clock).
module tb_pwl_clk_quantizer;

    localparam int unsigned NBIT = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   rdy;
    real                    in_a;
    real                    in_b;
    real                    in_t0;
    logic signed [NBIT-1:0] sample;
    logic                   sat;
    logic signed [NBIT-1:0] dout;
    logic                   dout_valid;
    logic                   ovf;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic                   rst;
        logic                   en;
        logic                   rdy;
        int                     a_mv;
        logic signed [NBIT-1:0] sample;
        logic                   sat;
        logic signed [NBIT-1:0] dout;
        logic                   valid;
        logic                   ovf;
    } vec_t;

    vec_t vecs [15];

    pwl_clk_quantizer #(
        .NBIT (8),
        .DEC  (4),
        .LSB  (0.01),
        .VOFS (0.0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_in_a       (in_a),
        .i_in_b       (in_b),
        .i_in_t0      (in_t0),
        .o_sample     (sample),
        .o_sat        (sat),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .i_dout_ready (rdy),
        .o_ovf        (ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic r, input logic e, input logic d, input int a_mv,
                                 input int s, input logic st, input int dv, input logic v,
                                 input logic o);
        vec_t x;
        x.rst    = r;
        x.en     = e;
        x.rdy    = d;
        x.a_mv   = a_mv;
        x.sample = NBIT'(s);
        x.sat    = st;
        x.dout   = NBIT'(dv);
        x.valid  = v;
        x.ovf    = o;
        return x;
    endfunction

    // Drive inputs, take one rising edge, land 2 ns after it.
    task automatic edge_step(input logic r, input logic e, input logic d);
        rst = r;
        en  = e;
        rdy = d;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int exp_s, input logic exp_sat,
                         input int exp_d, input logic exp_v, input logic exp_o);
        logic signed [NBIT-1:0] es;
        logic signed [NBIT-1:0] ed;
        es = NBIT'(exp_s);
        ed = NBIT'(exp_d);
        n_vec++;
        if (sample !== es || sat !== exp_sat || dout !== ed || dout_valid !== exp_v ||
            ovf !== exp_o) begin
            n_err++;
            $display("FAIL %s @%0t: got sample=%0d sat=%0b dout=%0d valid=%0b ovf=%0b, want sample=%0d sat=%0b dout=%0d valid=%0b ovf=%0b",
                     name, $time, sample, sat, dout, dout_valid, ovf, es, exp_sat, ed,
                     exp_v, exp_o);
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        rdy   = 1'b1;
        in_a  = 0.0;
        in_b  = 0.0;
        in_t0 = 0.0;

        // Reset, constant 0.123 V, then saturation and rounding corners.
        vecs[0]  = mkv(1'b1, 1'b0, 1'b1,     0,    0, 1'b0,  0, 1'b0, 1'b0);
        vecs[1]  = mkv(1'b0, 1'b1, 1'b1,   123,   12, 1'b0,  0, 1'b0, 1'b0);
        vecs[2]  = mkv(1'b0, 1'b1, 1'b1,   123,   12, 1'b0,  0, 1'b0, 1'b0);
        vecs[3]  = mkv(1'b0, 1'b1, 1'b1,   123,   12, 1'b0,  0, 1'b0, 1'b0);
        vecs[4]  = mkv(1'b0, 1'b1, 1'b1,   123,   12, 1'b0, 12, 1'b1, 1'b0);
        vecs[5]  = mkv(1'b0, 1'b1, 1'b1,   123,   12, 1'b0, 12, 1'b0, 1'b0);
        vecs[6]  = mkv(1'b0, 1'b1, 1'b1,   123,   12, 1'b0, 12, 1'b0, 1'b0);
        vecs[7]  = mkv(1'b0, 1'b1, 1'b1,   123,   12, 1'b0, 12, 1'b0, 1'b0);
        vecs[8]  = mkv(1'b0, 1'b1, 1'b1,   123,   12, 1'b0, 12, 1'b1, 1'b0);
        vecs[9]  = mkv(1'b0, 1'b1, 1'b1,  2000,  127, 1'b1, 12, 1'b0, 1'b0);
        vecs[10] = mkv(1'b0, 1'b1, 1'b1, -2000, -128, 1'b1, 12, 1'b0, 1'b0);
        vecs[11] = mkv(1'b0, 1'b1, 1'b1,  1270,  127, 1'b0, 12, 1'b0, 1'b0);
        vecs[12] = mkv(1'b0, 1'b1, 1'b1,    -5,   -1, 1'b0, 31, 1'b1, 1'b0);
        vecs[13] = mkv(1'b0, 1'b0, 1'b1,     0,   -1, 1'b0, 31, 1'b0, 1'b0);
        vecs[14] = mkv(1'b0, 1'b0, 1'b1,     0,   -1, 1'b0, 31, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            in_a = real'(vecs[i].a_mv) / 1000.0;
            edge_step(vecs[i].rst, vecs[i].en, vecs[i].rdy);
            check($sformatf("vec%0d", i), int'(vecs[i].sample), vecs[i].sat,
                  int'(vecs[i].dout), vecs[i].valid, vecs[i].ovf);
        end

        // Ramp 1e6 V/s; t0 puts the next edge 10 ns after t0 (now = edge + 2 ns).
        in_a  = 0.0;
        in_b  = 1.0e6;
        in_t0 = ($realtime - 2.0) * 1.0e-9;
        for (int k = 1; k <= 4; k++) begin
            edge_step(1'b0, 1'b1, 1'b1);
            check("ramp_up", k, 1'b0, (k == 4) ? 2 : 31, k == 4, 1'b0);
        end
        in_a  = -0.05;
        in_t0 = ($realtime - 2.0) * 1.0e-9;
        for (int k = 1; k <= 4; k++) begin
            edge_step(1'b0, 1'b1, 1'b1);
            check("ramp_down", k - 5, 1'b0, (k == 4) ? -3 : 2, k == 4, 1'b0);
        end

        // Backpressure: second result must be dropped and flagged.
        in_b  = 0.0;
        in_t0 = 0.0;
        in_a  = 0.123;
        edge_step(1'b1, 1'b0, 1'b1);
        check("bp_reset", 0, 1'b0, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            in_a = (k <= 4) ? 0.123 : 0.5;
            edge_step(1'b0, 1'b1, 1'b0);
            check("bp_hold", (k <= 4) ? 12 : 50, 1'b0, (k >= 4) ? 12 : 0, k >= 4, k == 8);
        end
        edge_step(1'b0, 1'b1, 1'b1);
        check("bp_release", 50, 1'b0, 12, 1'b0, 1'b1);

        // Reset in the middle of a block clears everything, including ovf.
        edge_step(1'b0, 1'b1, 1'b1);
        check("mid_block", 50, 1'b0, 12, 1'b0, 1'b1);
        edge_step(1'b1, 1'b1, 1'b1);
        check("mid_reset", 0, 1'b0, 0, 1'b0, 1'b0);
        in_a = 0.123;
        for (int k = 1; k <= 4; k++) begin
            edge_step(1'b0, 1'b1, 1'b1);
            check("post_reset", 12, 1'b0, (k == 4) ? 12 : 0, k == 4, 1'b0);
        end

        // Reset pulse entirely between edges must be ignored.
        rst = 1'b0;
        en  = 1'b0;
        rdy = 1'b1;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        check("rst_glitch", 12, 1'b0, 12, 1'b0, 1'b0);

        // Enable pattern 1,0,1,0,1,1: disabled edges see 0.9 V and must not count.
        for (int k = 1; k <= 6; k++) begin
            logic e;
            e    = (k == 1 || k == 3 || k >= 5);
            in_a = e ? 0.10 : 0.9;
            edge_step(1'b0, e, 1'b1);
            check("en_toggle", 10, 1'b0, (k == 6) ? 10 : 12, k == 6, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
